// File: rtl/alu_ctrl_stage.sv
// ALU-control pipeline stage: decodes the ALU operation, holds it under a valid/ready
// handshake, keeps the {N,Z,C} flag register and resolves B.cond branches on retire.
module alu_ctrl_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  input  logic        is_bcond,
  input  logic [3:0]  cond,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ALUctrl,
  input  logic        Z,
  input  logic        C,
  input  logic        N,
  output logic        illegal,
  output logic [2:0]  flags,
  output logic        br_valid,
  output logic        br_taken
);

  logic [3:0] dec_ctrl;
  logic       dec_sf;
  logic       dec_ill;

  logic       set_flags_q;
  logic       is_bcond_q;
  logic [3:0] cond_q;

  logic       accept;
  logic       retire;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign retire   = out_valid && out_ready && !flush;

  always_comb begin
    dec_ctrl = 4'b0000;
    dec_sf   = 1'b0;
    dec_ill  = 1'b0;
    if (is_bcond) begin
      dec_ctrl = 4'b0111;
    end else begin
      case (alu_op)
        2'b00: dec_ctrl = 4'b0010;
        2'b01: dec_ctrl = 4'b0111;
        2'b10: begin
          case (opcode)
            11'b10001011000: dec_ctrl = 4'b0010;
            11'b11001011000: dec_ctrl = 4'b0110;
            11'b10001010000: dec_ctrl = 4'b0000;
            11'b10101010000: dec_ctrl = 4'b0001;
            11'b10101011000: begin dec_ctrl = 4'b0010; dec_sf = 1'b1; end
            11'b11101011000: begin dec_ctrl = 4'b0110; dec_sf = 1'b1; end
            default:         dec_ill = 1'b1;
          endcase
        end
        default: begin
          // I-type opcodes are only 10 bits wide; opcode[0] belongs to the immediate
          case (opcode[10:1])
            10'b1001000100: dec_ctrl = 4'b0010;
            10'b1101000100: dec_ctrl = 4'b0110;
            10'b1001001000: dec_ctrl = 4'b0000;
            10'b1011001000: dec_ctrl = 4'b0001;
            10'b1011000100: begin dec_ctrl = 4'b0010; dec_sf = 1'b1; end
            10'b1111000100: begin dec_ctrl = 4'b0110; dec_sf = 1'b1; end
            default:        dec_ill = 1'b1;
          endcase
        end
      endcase
    end
  end

  function automatic logic cond_eval(input logic [3:0] c, input logic [2:0] f);
    logic res;
    case (c)
      4'b0000: res = f[1];
      4'b0001: res = !f[1];
      4'b0010: res = f[0];
      4'b0011: res = !f[0];
      4'b0100: res = f[2];
      4'b0101: res = !f[2];
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      ALUctrl     <= 4'b0000;
      illegal     <= 1'b0;
      set_flags_q <= 1'b0;
      is_bcond_q  <= 1'b0;
      cond_q      <= 4'b0000;
      flags       <= 3'b000;
      br_valid    <= 1'b0;
      br_taken    <= 1'b0;
    end else begin
      br_valid <= 1'b0;
      if (retire && set_flags_q) begin
        flags <= {N, Z, C};
      end
      // Branch sees the flag register as it stood before this cycle's update
      if (retire && is_bcond_q) begin
        br_valid <= 1'b1;
        br_taken <= cond_eval(cond_q, flags);
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        ALUctrl     <= dec_ctrl;
        illegal     <= dec_ill;
        set_flags_q <= dec_sf;
        is_bcond_q  <= is_bcond;
        cond_q      <= cond;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: driver pushes decoded expectations on accept,
// monitor checks held op, flags and branch pulses against a behavioural model.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [10:0] opcode = '0;
  logic        is_bcond = 1'b0;
  logic [3:0]  cond = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ALUctrl;
  logic        Z = 1'b0;
  logic        C = 1'b0;
  logic        N = 1'b0;
  logic        illegal;
  logic [2:0]  flags;
  logic        br_valid;
  logic        br_taken;

  alu_ctrl_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .opcode(opcode), .is_bcond(is_bcond), .cond(cond),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .ALUctrl(ALUctrl), .Z(Z), .C(C), .N(N), .illegal(illegal),
    .flags(flags), .br_valid(br_valid), .br_taken(br_taken)
  );

  always #5 clk = !clk;

  typedef struct {
    logic [3:0] ctrl;
    logic       ill;
    logic       sf;
    logic       bc;
    logic [3:0] cnd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // R-type full opcodes and I-type 10-bit opcodes; last two entries set flags
  logic [10:0] r_opc [6] = '{11'b10001011000, 11'b11001011000, 11'b10001010000,
                             11'b10101010000, 11'b10101011000, 11'b11101011000};
  logic [9:0]  i_opc [6] = '{10'b1001000100, 10'b1101000100, 10'b1001001000,
                             10'b1011001000, 10'b1011000100, 10'b1111000100};
  logic [3:0]  tab_ctrl [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0110};

  function automatic exp_t model(input logic [1:0] aop, input logic [10:0] opc,
                                 input logic bc, input logic [3:0] cnd);
    exp_t e;
    e.ctrl = 4'b0000; e.ill = 1'b0; e.sf = 1'b0; e.bc = bc; e.cnd = cnd;
    if (bc) e.ctrl = 4'b0111;
    else if (aop == 2'd0) e.ctrl = 4'b0010;
    else if (aop == 2'd1) e.ctrl = 4'b0111;
    else begin
      e.ill = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if ((aop == 2'd2 && opc == r_opc[i]) || (aop == 2'd3 && opc[10:1] == i_opc[i])) begin
          e.ctrl = tab_ctrl[i];
          e.sf   = (i >= 4);
          e.ill  = 1'b0;
        end
      end
    end
    return e;
  endfunction

  function automatic logic eval(input logic [3:0] c, input logic [2:0] nzc);
    logic n, z, cy;
    {n, z, cy} = nzc;
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compares at the falling edge, then advances the model across the next rising edge
  logic [3:0] last_ctrl = 4'b0000;
  logic       last_ill  = 1'b0;
  logic [2:0] m_flags   = 3'b000;
  logic       br_due    = 1'b0;
  logic       br_exp    = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      automatic logic held = (exp_q.size() != 0);
      automatic exp_t fr;
      check("out_valid", {3'b0, out_valid}, {3'b0, held});
      check("in_ready", {3'b0, in_ready}, {3'b0, !held || out_ready});
      if (held) begin
        check("ALUctrl", ALUctrl, exp_q[0].ctrl);
        check("illegal", {3'b0, illegal}, {3'b0, exp_q[0].ill});
      end else begin
        check("ALUctrl_hold", ALUctrl, last_ctrl);
        check("illegal_hold", {3'b0, illegal}, {3'b0, last_ill});
      end
      check("flags", {1'b0, flags}, {1'b0, m_flags});
      check("br_valid", {3'b0, br_valid}, {3'b0, br_due});
      if (br_due) check("br_taken", {3'b0, br_taken}, {3'b0, br_exp});

      br_due = 1'b0;
      if (rst) begin
        exp_q.delete();
        last_ctrl = 4'b0000;
        last_ill  = 1'b0;
        m_flags   = 3'b000;
      end else if (held && (flush || out_ready)) begin
        fr = exp_q.pop_front();
        last_ctrl = fr.ctrl;
        last_ill  = fr.ill;
        if (!flush) begin
          if (fr.bc) begin
            br_due = 1'b1;
            br_exp = eval(fr.cnd, m_flags);
          end
          if (fr.sf) m_flags = {N, Z, C};
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] aop, input logic [10:0] opc,
                       input logic bc, input logic [3:0] cnd, input logic rdy,
                       input logic fl, input logic [2:0] nzc, input logic r);
    logic acc;
    exp_t e;
    in_valid = v; alu_op = aop; opcode = opc; is_bcond = bc; cond = cnd;
    out_ready = rdy; flush = fl; {N, Z, C} = nzc; rst = r;
    acc = !r && v && !fl && (exp_q.size() == 0 || rdy);
    e = model(aop, opc, bc, cnd);
    @(posedge clk);
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 11'd0, 1'b0, 4'd0, rdy, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 2'd0, 11'd0, 1'b0, 4'd0, 1'b0, 1'b0, 3'b000, 1'b1);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();
    idle(2, 1'b1);

    // decode sweep
    for (int i = 0; i < 6; i++) drive(1'b1, 2'd2, r_opc[i], 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b1, 2'd3, {i_opc[i], 1'(i & 1)}, 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 2'd2, 11'b11111111111, 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 2'd0, 11'd5, 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 2'd1, 11'd9, 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b0);
    idle(2, 1'b1);

    // SUBS Z=1 C=1 then B.EQ, B.NE
    drive(1'b1, 2'd2, r_opc[5], 1'b0, 4'd0, 1'b1, 1'b0, 3'b011, 1'b0);
    drive(1'b1, 2'd2, 11'd0, 1'b1, 4'b0000, 1'b1, 1'b0, 3'b011, 1'b0);
    drive(1'b1, 2'd2, 11'd0, 1'b1, 4'b0001, 1'b1, 1'b0, 3'b011, 1'b0);
    idle(3, 1'b1);

    // stall three cycles with a waiting op, then retire and load together
    drive(1'b1, 2'd2, r_opc[1], 1'b0, 4'd0, 1'b0, 1'b0, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd3, {i_opc[3], 1'b0}, 1'b0, 4'd0, 1'b0, 1'b0, 3'b111, 1'b0);
    drive(1'b1, 2'd3, {i_opc[3], 1'b0}, 1'b0, 4'd0, 1'b1, 1'b0, 3'b111, 1'b0);
    idle(2, 1'b1);

    // flush of a held ADDS
    do_reset();
    drive(1'b1, 2'd2, r_opc[4], 1'b0, 4'd0, 1'b0, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 2'd2, r_opc[4], 1'b0, 4'd0, 1'b1, 1'b1, 3'b010, 1'b0);
    idle(2, 1'b1);

    // reset while a B.cond is stalled
    drive(1'b1, 2'd0, 11'd0, 1'b1, 4'b1110, 1'b0, 1'b0, 3'b000, 1'b0);
    idle(2, 1'b0);
    drive(1'b0, 2'd0, 11'd0, 1'b0, 4'd0, 1'b1, 1'b0, 3'b000, 1'b1);
    idle(3, 1'b1);

    // ADDS N=1 C=1 then B.MI, B.HS back to back
    do_reset();
    drive(1'b1, 2'd2, r_opc[4], 1'b0, 4'd0, 1'b1, 1'b0, 3'b101, 1'b0);
    drive(1'b1, 2'd0, 11'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 3'b101, 1'b0);
    drive(1'b1, 2'd0, 11'd0, 1'b1, 4'b0010, 1'b1, 1'b0, 3'b101, 1'b0);
    idle(3, 1'b1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      automatic logic [1:0]  aop = 2'($urandom_range(0, 3));
      automatic logic [10:0] opc = 11'($urandom);
      automatic int          sel = $urandom_range(0, 5);
      if ($urandom_range(0, 9) < 7) begin
        if (aop == 2'd2) opc = r_opc[sel];
        else if (aop == 2'd3) opc = {i_opc[sel], 1'($urandom)};
      end
      drive(1'($urandom_range(0, 3) != 0), aop, opc, 1'($urandom_range(0, 5) == 0),
            4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
            3'($urandom), 1'($urandom_range(0, 199) == 0));
    end
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 in_valid  in  1  decode-stage instruction present.
REQ-005 in_ready  out  1  stage can accept; combinational, = !out_valid | out_ready.
REQ-006 alu_op  in  2  main-control class: 00 mem, 01 CBZ, 10 R-type, 11 I-type.
REQ-007 opcode  in  11  instruction[31:21].
REQ-008 is_bcond  in  1  instruction is B.cond.
REQ-009 cond  in  4  B.cond condition field.
REQ-010 flush  in  1  discard held and incoming instruction.
REQ-011 out_valid  out  1  ALUctrl register holds a live op.
REQ-012 out_ready  in  1  execute stage consumes op this cycle (retire).
REQ-013 ALUctrl  out  4  registered ALU operation select.
REQ-014 Z, C  in  1 each  ALU zero/carry for current ALUctrl.
REQ-015 N  in  1  ALUres[63].
REQ-016 illegal  out  1  registered; held op has unrecognised opcode.
REQ-017 flags  out  3  {N,Z,C} flag register.
REQ-018 br_valid  out  1  one-cycle pulse: B.cond resolved.
REQ-019 br_taken  out  1  B.cond outcome, meaningful only with br_valid.

Function
REQ-020 Accept when in_valid & in_ready & !flush; load ALUctrl, set_flags, is_bcond, cond, illegal; out_valid=1 next cycle.
REQ-021 Decode: alu_op 00 -> 0010; 01 -> 0111; is_bcond -> 0111 regardless of alu_op.
REQ-022 R-type: ADD 10001011000 -> 0010; SUB 11001011000 -> 0110; AND 10001010000 -> 0000; ORR 10101010000 -> 0001; ADDS 10101011000 -> 0010 + set_flags; SUBS 11101011000 -> 0110 + set_flags.
REQ-023 I-type on opcode[10:1]: ADDI 1001000100 -> 0010; SUBI 1101000100 -> 0110; ANDI 1001001000 -> 0000; ORRI 1011001000 -> 0001; ADDIS 1011000100 -> 0010 + set_flags; SUBIS 1111000100 -> 0110 + set_flags.
REQ-024 Unmatched R/I opcode: ALUctrl=0000, set_flags=0, illegal=1; op still flows and retires.
REQ-025 Retire = out_valid & out_ready & !flush; without retire and without new accept, registers hold (stall).
REQ-026 Retire with set_flags: flags <= {N,Z,C} sampled that cycle.
REQ-027 Retire with is_bcond: next cycle br_valid=1, br_taken = eval(cond, flags register value at retire).
REQ-028 eval: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 1110 1; all others 0.
REQ-029 Retire and accept in same cycle: new op loaded, out_valid stays 1 (back-to-back, full throughput).
REQ-030 Retire without accept: out_valid=0 next cycle; ALUctrl, illegal hold last value.
REQ-031 flush: out_valid=0 next cycle; held op not retired, no flag update, no br_valid; incoming op dropped.
REQ-032 br_valid is exactly one cycle per retired B.cond; never asserted otherwise.

Reset
REQ-033 rst overrides flush and all handshakes, including mid-stall.
REQ-034 Post-reset: out_valid=0, ALUctrl=0000, illegal=0, flags=000, br_valid=0, br_taken=0; in_ready=1 combinationally.

Verification
REQ-035 Decode sweep: each REQ-022/023 opcode with out_ready=1 -> ALUctrl matches table one cycle after accept, illegal=0; opcode 11111111111 alu_op=10 -> ALUctrl=0000, illegal=1.
REQ-036 SUBS retire with Z=1,C=1,N=0, then B.EQ (cond=0000) retires -> flags=011, br_valid pulse, br_taken=1; repeat with B.NE -> br_taken=0.
REQ-037 Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, ALUctrl stable, no flag change; out_ready=1 -> retire and new op loaded same cycle.
REQ-038 ADDS held, flush=1 with out_ready=1, Z=1 -> flags unchanged (000), out_valid=0 next cycle, no br_valid.
REQ-039 rst asserted while B.cond held and stalled -> next cycle all outputs per REQ-034, br_valid never pulses.
REQ-040 Back-to-back ADDS(Z=0,C=1,N=1) then B.MI then B.HS, out_ready=1 -> flags=101, two br_valid pulses, br_taken=1 both.
